// File: rtl/tt_um_seq_divider.sv
// Sequential 8-bit unsigned restoring divider in the Tiny Tapeout user-module frame.
// Define DIV_RADIX4_EN to resolve two quotient bits per CALC cycle.
module tt_um_seq_divider (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 3;
`ifdef DIV_RADIX4_EN
    localparam logic [CW-1:0] CNT_INIT = CW'(3);
`else
    localparam logic [CW-1:0] CNT_INIT = CW'(7);
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    a_q, b_q, q_q, qr_q, rr_q;
    logic [W:0]      r_q;
    logic [CW-1:0]   cnt_q;
    logic            start_q, done_q, dz_q;
    logic            start_go, dz_go, finish;
    logic            load_a, load_b, start, out_sel, start_edge;
    logic [W+1:0]    s1;
    logic [W:0]      r1, r_step;
    logic [W-1:0]    q1, q_step;

    assign load_a     = uio_in[0];
    assign load_b     = uio_in[1];
    assign start      = uio_in[2];
    assign out_sel    = uio_in[3];
    assign start_edge = start & ~start_q;

    wire unused_ok = &{1'b0, ena, uio_in[7:4], r_q[W], r1[W]};

    // One restoring step: returns {new partial remainder, quotient bit}.
    function automatic logic [W+1:0] div_step(input logic [W-1:0] r,
                                              input logic         qin,
                                              input logic [W-1:0] d);
        logic [W:0]   rs;
        logic [W+1:0] diff;
        rs   = {r, qin};
        diff = {1'b0, rs} - {2'b00, d};
        if (!diff[W+1]) div_step = {diff[W:0], 1'b1};
        else            div_step = {rs, 1'b0};
    endfunction

    always_comb begin
        s1 = div_step(r_q[W-1:0], q_q[W-1], b_q);
        r1 = s1[W+1:1];
        q1 = {q_q[W-2:0], s1[0]};
    end

`ifdef DIV_RADIX4_EN
    logic [W+1:0] s2;
    always_comb begin
        s2     = div_step(r1[W-1:0], q1[W-1], b_q);
        r_step = s2[W+1:1];
        q_step = {q1[W-2:0], s2[0]};
    end
`else
    always_comb begin
        r_step = r1;
        q_step = q1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_go  = 1'b0;
        dz_go     = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_edge) begin
                    if (b_q != '0) begin
                        state_nxt = ST_CALC;
                        start_go  = 1'b1;
                    end else begin
                        state_nxt = ST_DONE;
                        dz_go     = 1'b1;
                    end
                end
            end
            ST_CALC: begin
                if (cnt_q == '0) begin
                    state_nxt = ST_DONE;
                    finish    = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand, iteration and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            qr_q    <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            start_q <= start;
            if (state != ST_CALC) begin
                if (load_a) a_q <= ui_in;
                if (load_b) b_q <= ui_in;
            end
            if (start_go) begin
                r_q    <= '0;
                q_q    <= a_q;
                cnt_q  <= CNT_INIT;
                done_q <= 1'b0;
                dz_q   <= 1'b0;
            end else if (dz_go) begin
                qr_q   <= 8'hFF;
                rr_q   <= a_q;
                dz_q   <= 1'b1;
                done_q <= 1'b1;
            end else if (state == ST_CALC) begin
                r_q   <= r_step;
                q_q   <= q_step;
                cnt_q <= cnt_q - CW'(1);
                if (finish) begin
                    qr_q   <= q_step;
                    rr_q   <= r_step[W-1:0];
                    done_q <= 1'b1;
                end
            end
        end
    end

    // Result select is a live mux so out_sel acts within the same cycle.
    always_comb begin
        uo_out  = out_sel ? rr_q : qr_q;
        uio_out = {1'b0, dz_q, done_q, (state == ST_CALC), 4'b0000};
        uio_oe  = 8'b0111_0000;
    end

endmodule

// File: tb/tb_tt_um_seq_divider.sv
// Scoreboard bench for tt_um_seq_divider; expected results queued at start, checked at done.
module tb_tt_um_seq_divider;

`ifdef DIV_RADIX4_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 8;
`endif

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    tt_um_seq_divider dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk); ui_in = a; uio_in = 8'h01;
        @(negedge clk); ui_in = b; uio_in = 8'h02;
        @(negedge clk); uio_in = 8'h00;
    endtask

    // Start a run on the loaded operands (a,b as the model's view of them) and check it.
    task automatic go(input logic [7:0] a, input logic [7:0] b, input bit disturb);
        exp_t e;
        int   waited;
        int   busy_cnt;
        if (b == 8'd0) e = '{q: 8'hFF, r: a, dz: 1'b1};
        else           e = '{q: a / b, r: a % b, dz: 1'b0};
        @(negedge clk); uio_in = 8'h04;
        sb.push_back(e);
        @(negedge clk); uio_in = 8'h00;
        waited = 0; busy_cnt = 0;
        while (!uio_out[5] && waited < 40) begin
            if (uio_out[4]) busy_cnt++;
            if (disturb) begin
                case (waited)
                    2: uio_in = 8'h04;
                    3: begin uio_in = 8'h01; ui_in = 8'd9; end
                    4: uio_in = 8'h00;
                    default: ;
                endcase
            end
            waited++;
            @(negedge clk);
        end
        e = sb.pop_front();
        check("timeout", 32'(waited < 40), 32'(1));
        check("latency", 32'(waited), e.dz ? 32'(0) : 32'(LAT));
        check("busy_cycles", 32'(busy_cnt), e.dz ? 32'(0) : 32'(LAT));
        check("busy_at_done", 32'(uio_out[4]), 32'(0));
        check("dz", 32'(uio_out[6]), 32'(e.dz));
        check("quotient", 32'(uo_out), 32'(e.q));
        uio_in = 8'h08;
        #1 check("remainder", 32'(uo_out), 32'(e.r));
        uio_in = 8'h00;
        #1 check("quotient_back", 32'(uo_out), 32'(e.q));
    endtask

    initial begin
        int busy_cnt;
        rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_uo_out", 32'(uo_out), 32'(0));
        check("rst_uio_out", 32'(uio_out), 32'(0));
        check("uio_oe", 32'(uio_oe), 32'h70);
        rst_n = 1'b1;

        load(8'd100, 8'd7);  go(8'd100, 8'd7, 1'b0);
        load(8'd255, 8'd1);  go(8'd255, 8'd1, 1'b0);
        load(8'd7, 8'd9);    go(8'd7, 8'd9, 1'b0);
        load(8'd5, 8'd0);    go(8'd5, 8'd0, 1'b0);
        load(8'd0, 8'd255);  go(8'd0, 8'd255, 1'b0);

        // Reload in DONE must leave the held results intact.
        @(negedge clk); ui_in = 8'd42; uio_in = 8'h03;
        @(negedge clk); uio_in = 8'h00;
        check("hold_q_after_reload", 32'(uo_out), 32'(0));
        go(8'd42, 8'd42, 1'b0);

        // Start pulse and load_a during CALC are ignored.
        load(8'd200, 8'd3);  go(8'd200, 8'd3, 1'b1);
        busy_cnt = 0;
        repeat (12) begin @(negedge clk); if (uio_out[4]) busy_cnt++; end
        check("no_extra_run", 32'(busy_cnt), 32'(0));
        go(8'd200, 8'd3, 1'b0);

        // Asynchronous reset mid-run.
        load(8'd100, 8'd7);
        @(negedge clk); uio_in = 8'h04;
        @(negedge clk); uio_in = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1 check("abort_uo_out", 32'(uo_out), 32'(0));
        check("abort_uio_out", 32'(uio_out), 32'(0));
        uio_in = 8'h08;
        #1 check("abort_rr", 32'(uo_out), 32'(0));
        uio_in = 8'h00;
        @(negedge clk); rst_n = 1'b1;
        go(8'd0, 8'd0, 1'b0);
        load(8'd50, 8'd5);   go(8'd50, 8'd5, 1'b0);

        // Holding start high triggers exactly one run.
        load(8'd100, 8'd7);
        busy_cnt = 0;
        @(negedge clk); uio_in = 8'h04;
        repeat (20) begin @(negedge clk); if (uio_out[4]) busy_cnt++; end
        check("held_start_runs", 32'(busy_cnt), 32'(LAT));
        check("held_start_done", 32'(uio_out[5]), 32'(1));
        check("held_start_q", 32'(uo_out), 32'(14));
        @(negedge clk); uio_in = 8'h00;

        for (int i = 0; i < 6; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (i == 0) rb = 8'd0;
            load(ra, rb);
            go(ra, rb, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
